bp_profiler_stall_histogram: RTL and testbench
==============================================

# bp_profiler_stall_histogram

Synthesizable consumer of the per-cycle stall-attribution stream produced by the core stall profiler. Each cycle it receives either a retired-instruction flag or one encoded stall reason, and increments the matching saturating counter. The host reads the accumulated histogram through a single-outstanding request/response port, which the shell maps onto the AXI-lite CSR space. It sits beside the core, after the profiler's final-stage priority encode.

## Interface
Parameters:
- counter_width_p, 32, width of every histogram counter.
- num_bins_lp, 32 (localparam), bins 0–30 are the bp_stall_reason_e values and bin 31 is instructions retired.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  reset; synchronous, active-high.
- freeze_i  in  1  core frozen; no counting while high.
- v_i  in  1  a stream record is present this cycle.
- instret_i  in  1  record is a retired instruction; overrides reason_i.
- reason_i  in  5  bp_stall_reason_e code; used when instret_i is 0.
- clear_i  in  1  zero all counters.
- snapshot_i  in  1  capture all counters into the shadow bank (only with the macro).
- rd_v_i  in  1  read request valid.
- rd_addr_i  in  5  bin index to read.
- rd_ready_o  out  1  request accepted when rd_v_i & rd_ready_o.
- rd_v_o  out  1  response valid.
- rd_data_o  out  counter_width_p  counter value.
- rd_yumi_i  in  1  response consumed.

## Operation
- Count enable = v_i & ~freeze_i & ~reset_i. Target bin = instret_i ? 31 : reason_i. Exactly one bin increments per enabled cycle.
- reason_i = 31 with instret_i = 0 is illegal. It must not increment any counter and fires an assertion in simulation.
- Counters saturate at 2^counter_width_p − 1 and hold there; they never wrap.
- clear_i zeroes every counter at the next edge. If clear_i and an increment occur in the same cycle, clear wins and the result is 0.
- Read port has two states:
  - IDLE: rd_ready_o = 1, rd_v_o = 0. On rd_v_i, latch rd_data_o from the selected bank and go to RESP.
  - RESP: rd_ready_o = 0, rd_v_o = 1, rd_data_o held stable. On rd_yumi_i, return to IDLE.
- Returned value is the counter as registered at the accept edge. It excludes any increment occurring in that same cycle.
- A clear_i while in RESP does not alter the already-latched rd_data_o.

## Timing
- Reset values: all counters 0, shadow bank 0, state IDLE, rd_ready_o = 1, rd_v_o = 0, rd_data_o = 0.
- Increment latency: an event at cycle N is visible to a read accepted at cycle N+1.
- Read latency: request accepted at cycle N gives rd_v_o at N+1. Back-to-back throughput is one read every 2 cycles; rd_ready_o is not combinationally dependent on rd_yumi_i.
- Reset asserted mid-response drops the response at the next edge, with no yumi required.

## Configuration
- BP_PROFILER_SNAPSHOT_EN defined:
  - snapshot_i copies all 32 live counters to the shadow bank at the next edge.
  - Reads return the shadow bank, giving a coherent histogram across 32 reads.
  - snapshot_i and clear_i together: the shadow captures the pre-clear values, and the live bank clears.
  - An increment in the snapshot cycle goes to the live bank only.
- Undefined: no shadow bank, snapshot_i is ignored, and reads return live counters.

## Structure
- bp_profiler_pkg holds:
  - bp_stall_reason_e, shared with the stall profiler;
  - localparam bp_profiler_instret_bin_gp = 31;
  - localparam bp_profiler_num_bins_gp = 32.
- One sub-module, bp_profiler_sat_counter: a saturating counter with clear priority, instantiated num_bins_lp times.
- Read FSM and snapshot bank are in the top module.

## Test plan
- Reset, then 10 records with reason 3 (dcache_miss) and 5 with instret_i = 1; read bins 3 and 31 → 10 and 5; all other bins → 0.
- freeze_i = 1 during 8 records of reason 30 → bin 30 reads 0. v_i = 0 cycles count nothing.
- counter_width_p = 4, 20 records of reason 0 → bin 0 reads 15, saturated with no wrap.
- clear_i in the same cycle as a reason-7 record, after 4 prior reason-7 records → bin 7 reads 0.
- Read handshake:
  - hold rd_yumi_i low 5 cycles → rd_v_o and rd_data_o stay stable and rd_ready_o stays 0;
  - yumi → IDLE next cycle;
  - reset asserted in RESP → rd_v_o = 0 next cycle.
- With BP_PROFILER_SNAPSHOT_EN: 6 reason-2 records, snapshot_i, 4 more, then read bin 2 → 6. A second snapshot_i, then read bin 2 → 10.

Source files
------------

// File: rtl/bp_profiler_pkg.sv
// Shared types for the stall profiler and its histogram consumer: stall reason
// codes, bin layout constants and read-port FSM states.
package bp_profiler_pkg;

    localparam int bp_profiler_instret_bin_gp = 31;
    localparam int bp_profiler_num_bins_gp    = 32;

    // Code 31 is never a stall reason; that bin is reserved for retired instructions.
    typedef enum logic [4:0] {
        e_icache_miss        = 5'd0,
        e_branch_override    = 5'd1,
        e_itlb_miss          = 5'd2,
        e_dcache_miss        = 5'd3,
        e_dtlb_miss          = 5'd4,
        e_fe_queue_stall     = 5'd5,
        e_fe_wait_stall      = 5'd6,
        e_icache_fence       = 5'd7,
        e_branch_mispredict  = 5'd8,
        e_ret_override       = 5'd9,
        e_fpu_busy           = 5'd10,
        e_long_haz           = 5'd11,
        e_mul_haz            = 5'd12,
        e_fma_haz            = 5'd13,
        e_sb_iraw_dep        = 5'd14,
        e_sb_fraw_dep        = 5'd15,
        e_sb_iwaw_dep        = 5'd16,
        e_sb_fwaw_dep        = 5'd17,
        e_struct_haz         = 5'd18,
        e_control_haz        = 5'd19,
        e_data_haz           = 5'd20,
        e_load_dep           = 5'd21,
        e_mul_dep            = 5'd22,
        e_fma_dep            = 5'd23,
        e_fence_stall        = 5'd24,
        e_cmd_fence          = 5'd25,
        e_mem_fence          = 5'd26,
        e_exception          = 5'd27,
        e_eret               = 5'd28,
        e_interrupt          = 5'd29,
        e_unknown            = 5'd30
    } bp_stall_reason_e;

    typedef enum logic {
        e_rd_idle = 1'b0,
        e_rd_resp = 1'b1
    } bp_profiler_rd_state_e;

    function automatic logic [4:0] bp_profiler_bin_sel(input logic       instret,
                                                       input logic [4:0] reason);
        return instret ? 5'(bp_profiler_instret_bin_gp) : reason;
    endfunction

    function automatic logic bp_profiler_record_legal(input logic       instret,
                                                      input logic [4:0] reason);
        return instret || (reason != 5'(bp_profiler_instret_bin_gp));
    endfunction

endpackage

// File: rtl/bp_profiler_sat_counter.sv
// One histogram bin: counts up by one per increment, sticks at all-ones,
// and clears to zero with priority over a concurrent increment.
module bp_profiler_sat_counter
    import bp_profiler_pkg::*;
  #(parameter int counter_width_p = 32)
  (input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       clear_i,
   input  logic                       inc_i,
   output logic [counter_width_p-1:0] count_o);

    logic [counter_width_p-1:0] count_r;

    function automatic logic [counter_width_p-1:0] sat_inc(input logic [counter_width_p-1:0] val);
        if (&val)
            return val;
        return val + counter_width_p'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i)
            count_r <= '0;
        else if (inc_i)
            count_r <= sat_inc(count_r);
    end

    assign count_o = count_r;

endmodule

// File: rtl/bp_profiler_stall_histogram.sv
// Stall-attribution histogram: one saturating counter per stall reason plus retired
// instructions, read through a single-outstanding port. BP_PROFILER_SNAPSHOT_EN adds a shadow bank.
module bp_profiler_stall_histogram
    import bp_profiler_pkg::*;
  #(parameter int counter_width_p = 32)
  (input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       freeze_i,
   input  logic                       v_i,
   input  logic                       instret_i,
   input  logic [4:0]                 reason_i,
   input  logic                       clear_i,
   input  logic                       snapshot_i,
   input  logic                       rd_v_i,
   input  logic [4:0]                 rd_addr_i,
   output logic                       rd_ready_o,
   output logic                       rd_v_o,
   output logic [counter_width_p-1:0] rd_data_o,
   input  logic                       rd_yumi_i);

    localparam int num_bins_lp = bp_profiler_num_bins_gp;

    logic                       count_en_li;
    logic                       legal_li;
    logic [4:0]                 bin_li;
    logic [num_bins_lp-1:0]     inc_li;
    logic [counter_width_p-1:0] count_lo [num_bins_lp];

    assign count_en_li = v_i & ~freeze_i & ~reset_i;
    assign bin_li      = bp_profiler_bin_sel(instret_i, reason_i);
    assign legal_li    = bp_profiler_record_legal(instret_i, reason_i);

    always_comb begin
        inc_li = '0;
        if (count_en_li && legal_li)
            inc_li[bin_li] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (count_en_li)
            assert (legal_li)
                else $error("bp_profiler_stall_histogram: reason 31 presented without instret");
    end

    for (genvar b = 0; b < num_bins_lp; b++) begin : bin
        bp_profiler_sat_counter #(.counter_width_p(counter_width_p)) counter
          (.clk_i  (clk_i),
           .reset_i(reset_i),
           .clear_i(clear_i),
           .inc_i  (inc_li[b]),
           .count_o(count_lo[b]));
    end

    logic [counter_width_p-1:0] rd_sel_li;

`ifdef BP_PROFILER_SNAPSHOT_EN
    logic [counter_width_p-1:0] shadow_r [num_bins_lp];

    // Captures the registered live values, so a same-cycle clear or increment is not seen here.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            shadow_r <= '{default: '0};
        else if (snapshot_i)
            shadow_r <= count_lo;
    end

    assign rd_sel_li = shadow_r[rd_addr_i];
`else
    logic unused_snapshot;
    assign unused_snapshot = snapshot_i;
    assign rd_sel_li       = count_lo[rd_addr_i];
`endif

    bp_profiler_rd_state_e      state_r, state_n;
    logic                       rd_accept_li;
    logic [counter_width_p-1:0] rd_data_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= e_rd_idle;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n      = state_r;
        rd_ready_o   = 1'b0;
        rd_v_o       = 1'b0;
        rd_accept_li = 1'b0;
        case (state_r)
            e_rd_idle: begin
                rd_ready_o = 1'b1;
                if (rd_v_i) begin
                    rd_accept_li = 1'b1;
                    state_n      = e_rd_resp;
                end
            end
            e_rd_resp: begin
                rd_v_o = 1'b1;
                if (rd_yumi_i)
                    state_n = e_rd_idle;
            end
            default: state_n = e_rd_idle;
        endcase
    end

    // Latched once at accept; later clears or increments leave the response untouched.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            rd_data_r <= '0;
        else if (rd_accept_li)
            rd_data_r <= rd_sel_li;
    end

    assign rd_data_o = rd_data_r;

endmodule

// File: tb/tb_bp_profiler_stall_histogram.sv
// Self-checking bench: a 32-bit and a 4-bit histogram share one stimulus stream
// and are compared against an unbounded-count reference model.
module tb_bp_profiler_stall_histogram;

    logic        clk_i = 1'b0;
    logic        reset_i, freeze_i, v_i, instret_i, clear_i, snapshot_i;
    logic [4:0]  reason_i;
    logic        rd_v_i, rd_yumi_i;
    logic [4:0]  rd_addr_i;
    logic        rd_ready_o, rd_v_o;
    logic [31:0] rd_data_o;
    logic        rd_ready4, rd_v4;
    logic [3:0]  rd_data4;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned live_m   [32];
    longint unsigned shadow_m [32];

    always #5 clk_i = ~clk_i;

    bp_profiler_stall_histogram #(.counter_width_p(32)) dut
      (.clk_i(clk_i), .reset_i(reset_i), .freeze_i(freeze_i), .v_i(v_i),
       .instret_i(instret_i), .reason_i(reason_i), .clear_i(clear_i),
       .snapshot_i(snapshot_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
       .rd_ready_o(rd_ready_o), .rd_v_o(rd_v_o), .rd_data_o(rd_data_o),
       .rd_yumi_i(rd_yumi_i));

    bp_profiler_stall_histogram #(.counter_width_p(4)) dut4
      (.clk_i(clk_i), .reset_i(reset_i), .freeze_i(freeze_i), .v_i(v_i),
       .instret_i(instret_i), .reason_i(reason_i), .clear_i(clear_i),
       .snapshot_i(snapshot_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
       .rd_ready_o(rd_ready4), .rd_v_o(rd_v4), .rd_data_o(rd_data4),
       .rd_yumi_i(rd_yumi_i));

    // Reference model: what one clock edge does to the histogram.
    function automatic void model_step(input bit v, input bit ir, input logic [4:0] rs,
                                       input bit frz, input bit clr, input bit snp);
        if (snp)
            for (int b = 0; b < 32; b++) shadow_m[b] = live_m[b];
        if (clr)
            for (int b = 0; b < 32; b++) live_m[b] = 0;
        else if (v && !frz)
            live_m[ir ? 31 : int'(rs)] += 1;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 32; b++) begin
            live_m[b]   = 0;
            shadow_m[b] = 0;
        end
    endfunction

    function automatic longint unsigned src_m(input int b);
`ifdef BP_PROFILER_SNAPSHOT_EN
        return shadow_m[b];
`else
        return live_m[b];
`endif
    endfunction

    function automatic logic [31:0] exp32(input int b);
        return (src_m(b) >= 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(src_m(b));
    endfunction

    function automatic logic [3:0] exp4(input int b);
        return (src_m(b) >= 15) ? 4'hF : 4'(src_m(b));
    endfunction

    task automatic cycle(input bit v, input bit ir, input logic [4:0] rs,
                         input bit frz, input bit clr, input bit snp);
        v_i = v; instret_i = ir; reason_i = rs; freeze_i = frz; clear_i = clr; snapshot_i = snp;
        @(posedge clk_i);
        model_step(v, ir, rs, frz, clr, snp);
        #1;
        v_i = 0; instret_i = 0; reason_i = '0; freeze_i = 0; clear_i = 0; snapshot_i = 0;
    endtask

    task automatic take_snapshot();
        cycle(0, 0, 5'd0, 0, 0, 1);
    endtask

    task automatic clear_all();
        cycle(0, 0, 5'd0, 0, 1, 0);
    endtask

    // One complete read; ok drops if the handshake does not behave as a single transaction.
    task automatic do_read(input int addr, input bit rec_v, input logic [4:0] rec_rs,
                           output logic [31:0] d32, output logic [3:0] d4, output bit ok);
        ok = 1;
        if (!(rd_ready_o && rd_ready4)) ok = 0;
        rd_addr_i = 5'(addr); rd_v_i = 1;
        v_i = rec_v; reason_i = rec_rs;
        @(posedge clk_i);
        model_step(rec_v, 0, rec_rs, 0, 0, 0);
        #1;
        rd_v_i = 0; v_i = 0; reason_i = '0;
        if (!(rd_v_o && rd_v4)) ok = 0;
        d32 = rd_data_o;
        d4  = rd_data4;
        rd_yumi_i = 1;
        @(posedge clk_i);
        #1;
        rd_yumi_i = 0;
        if (rd_v_o || rd_v4 || !rd_ready_o || !rd_ready4) ok = 0;
    endtask

    task automatic test_reset();
        reset_i = 1;
        repeat (3) @(posedge clk_i);
        model_reset();
        #1;
        n_checks++;
        if (rd_ready_o !== 1'b1 || rd_v_o !== 1'b0 || rd_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b v=%b data=%0d, required ready=1 v=0 data=0",
                     rd_ready_o, rd_v_o, rd_data_o);
        end
        reset_i = 0;
        for (int b = 0; b < 32; b++) begin
            logic [31:0] d32; logic [3:0] d4; bit ok;
            do_read(b, 0, 5'd0, d32, d4, ok);
            n_checks++;
            if (!ok || d32 !== 32'd0 || d4 !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_bin%0d: got %0d/%0d ok=%0d, required 0/0 ok=1", b, d32, d4, ok);
            end
        end
    endtask

    task automatic test_basic_count();
        logic [31:0] d32; logic [3:0] d4; bit ok;
        repeat (10) cycle(1, 0, 5'd3, 0, 0, 0);
        repeat (5)  cycle(1, 1, 5'($urandom_range(0, 31)), 0, 0, 0);
        take_snapshot();
        do_read(3, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd10 || d4 !== 4'd10) begin
            n_fail++;
            $display("FAIL basic_bin3: got %0d/%0d ok=%0d, required 10/10", d32, d4, ok);
        end
        do_read(31, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd5 || d4 !== 4'd5) begin
            n_fail++;
            $display("FAIL basic_instret: got %0d/%0d ok=%0d, required 5/5", d32, d4, ok);
        end
        for (int b = 0; b < 32; b++) begin
            do_read(b, 0, 5'd0, d32, d4, ok);
            n_checks++;
            if (!ok || d32 !== exp32(b) || d4 !== exp4(b)) begin
                n_fail++;
                $display("FAIL basic_all_bin%0d: got %0d/%0d, required %0d/%0d", b, d32, d4, exp32(b), exp4(b));
            end
        end
    endtask

    task automatic test_freeze_and_idle();
        logic [31:0] d32; logic [3:0] d4; bit ok;
        repeat (8) cycle(1, 0, 5'd30, 1, 0, 0);
        repeat (6) cycle(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 0, 0, 0);
        take_snapshot();
        do_read(30, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd0 || d4 !== 4'd0) begin
            n_fail++;
            $display("FAIL freeze_bin30: got %0d/%0d, required 0/0", d32, d4);
        end
        for (int b = 0; b < 32; b++) begin
            do_read(b, 0, 5'd0, d32, d4, ok);
            n_checks++;
            if (!ok || d32 !== exp32(b) || d4 !== exp4(b)) begin
                n_fail++;
                $display("FAIL freeze_all_bin%0d: got %0d/%0d, required %0d/%0d", b, d32, d4, exp32(b), exp4(b));
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d32; logic [3:0] d4; bit ok;
        clear_all();
        repeat (20) cycle(1, 0, 5'd0, 0, 0, 0);
        take_snapshot();
        do_read(0, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd20 || d4 !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate_bin0: got %0d/%0d, required 20/15", d32, d4);
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] d32; logic [3:0] d4; bit ok;
        clear_all();
        repeat (4) cycle(1, 0, 5'd7, 0, 0, 0);
        cycle(1, 0, 5'd7, 0, 1, 0);
        take_snapshot();
        do_read(7, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd0 || d4 !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_wins_bin7: got %0d/%0d, required 0/0", d32, d4);
        end
        cycle(1, 0, 5'd7, 0, 0, 0);
        take_snapshot();
        do_read(7, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd1 || d4 !== 4'd1) begin
            n_fail++;
            $display("FAIL clear_recount_bin7: got %0d/%0d, required 1/1", d32, d4);
        end
    endtask

    task automatic test_read_timing();
        logic [31:0] d32, e32; logic [3:0] d4, e4; bit ok;
        clear_all();
        repeat (3) cycle(1, 0, 5'd12, 0, 0, 0);
        e32 = exp32(12); e4 = exp4(12);
        do_read(12, 1, 5'd12, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== e32 || d4 !== e4) begin
            n_fail++;
            $display("FAIL accept_excludes_inc: got %0d/%0d, required %0d/%0d", d32, d4, e32, e4);
        end
`ifndef BP_PROFILER_SNAPSHOT_EN
        n_checks++;
        if (d32 !== 32'd3) begin
            n_fail++;
            $display("FAIL accept_excludes_const: got %0d, required 3", d32);
        end
`endif
        e32 = exp32(12); e4 = exp4(12);
        do_read(12, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== e32 || d4 !== e4) begin
            n_fail++;
            $display("FAIL inc_latency: got %0d/%0d, required %0d/%0d", d32, d4, e32, e4);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] e32; logic [3:0] e4;
        clear_all();
        repeat (3) cycle(1, 0, 5'd5, 0, 0, 0);
        take_snapshot();
        e32 = exp32(5); e4 = exp4(5);
        n_checks++;
        if (rd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_idle_ready: got %b, required 1", rd_ready_o);
        end
        rd_addr_i = 5'd5; rd_v_i = 1;
        @(posedge clk_i);
        #1;
        rd_v_i = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 5'd5, 0, i == 2, i == 3);
            n_checks++;
            if (rd_v_o !== 1'b1 || rd_ready_o !== 1'b0 || rd_data_o !== e32 ||
                rd_v4 !== 1'b1 || rd_data4 !== e4) begin
                n_fail++;
                $display("FAIL hs_hold_%0d: v=%b ready=%b data=%0d/%0d, required v=1 ready=0 data=%0d/%0d",
                         i, rd_v_o, rd_ready_o, rd_data_o, rd_data4, e32, e4);
            end
        end
        rd_yumi_i = 1;
        @(posedge clk_i);
        #1;
        rd_yumi_i = 0;
        n_checks++;
        if (rd_v_o !== 1'b0 || rd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_yumi_idle: v=%b ready=%b, required v=0 ready=1", rd_v_o, rd_ready_o);
        end
        rd_addr_i = 5'd5; rd_v_i = 1;
        @(posedge clk_i);
        #1;
        rd_v_i = 0;
        n_checks++;
        if (rd_v_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_resp_before_reset: v=%b, required 1", rd_v_o);
        end
        reset_i = 1;
        @(posedge clk_i);
        model_reset();
        #1;
        reset_i = 0;
        n_checks++;
        if (rd_v_o !== 1'b0 || rd_ready_o !== 1'b1 || rd_data_o !== 32'd0 || rd_v4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_reset_drop: v=%b ready=%b data=%0d, required v=0 ready=1 data=0",
                     rd_v_o, rd_ready_o, rd_data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e32;
        repeat (4) cycle(1, 0, 5'd9, 0, 0, 0);
        take_snapshot();
        e32 = exp32(9);
        rd_addr_i = 5'd9; rd_v_i = 1; rd_yumi_i = 1;
        for (int i = 0; i < 6; i++) begin
            bit exp_v;
            exp_v = (i % 2) == 0;
            @(posedge clk_i);
            #1;
            n_checks++;
            if (rd_v_o !== exp_v || rd_v4 !== exp_v || (exp_v && rd_data_o !== e32)) begin
                n_fail++;
                $display("FAIL b2b_%0d: v=%b data=%0d, required v=%b data=%0d", i, rd_v_o, rd_data_o, exp_v, e32);
            end
        end
        rd_v_i = 0; rd_yumi_i = 0;
    endtask

    task automatic test_random();
        logic [31:0] d32, e32; logic [3:0] d4, e4; bit ok;
        for (int n = 0; n < 400; n++) begin
            bit v, ir, frz, clr, snp;
            logic [4:0] rs;
            v   = $urandom_range(0, 3) != 0;
            ir  = $urandom_range(0, 3) == 0;
            rs  = ir ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 30));
            frz = $urandom_range(0, 7) == 0;
            clr = $urandom_range(0, 149) == 0;
            snp = $urandom_range(0, 15) == 0;
            cycle(v, ir, rs, frz, clr, snp);
            if (n % 50 == 49) begin
                int b;
                b = $urandom_range(0, 31);
                e32 = exp32(b); e4 = exp4(b);
                do_read(b, 1, 5'($urandom_range(0, 30)), d32, d4, ok);
                n_checks++;
                if (!ok || d32 !== e32 || d4 !== e4) begin
                    n_fail++;
                    $display("FAIL random_mid_bin%0d: got %0d/%0d, required %0d/%0d", b, d32, d4, e32, e4);
                end
            end
        end
        take_snapshot();
        for (int b = 0; b < 32; b++) begin
            do_read(b, 0, 5'd0, d32, d4, ok);
            n_checks++;
            if (!ok || d32 !== exp32(b) || d4 !== exp4(b)) begin
                n_fail++;
                $display("FAIL random_bin%0d: got %0d/%0d, required %0d/%0d", b, d32, d4, exp32(b), exp4(b));
            end
        end
    endtask

`ifdef BP_PROFILER_SNAPSHOT_EN
    task automatic test_snapshot();
        logic [31:0] d32; logic [3:0] d4; bit ok;
        clear_all();
        take_snapshot();
        repeat (6) cycle(1, 0, 5'd2, 0, 0, 0);
        take_snapshot();
        repeat (4) cycle(1, 0, 5'd2, 0, 0, 0);
        do_read(2, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd6 || d4 !== 4'd6) begin
            n_fail++;
            $display("FAIL snap_first: got %0d/%0d, required 6/6", d32, d4);
        end
        cycle(1, 0, 5'd2, 0, 0, 1);
        do_read(2, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd10 || d4 !== 4'd10) begin
            n_fail++;
            $display("FAIL snap_second: got %0d/%0d, required 10/10", d32, d4);
        end
        cycle(0, 0, 5'd0, 0, 1, 1);
        do_read(2, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd11 || d4 !== 4'd11) begin
            n_fail++;
            $display("FAIL snap_with_clear: got %0d/%0d, required 11/11", d32, d4);
        end
        take_snapshot();
        do_read(2, 0, 5'd0, d32, d4, ok);
        n_checks++;
        if (!ok || d32 !== 32'd0 || d4 !== 4'd0) begin
            n_fail++;
            $display("FAIL snap_after_clear: got %0d/%0d, required 0/0", d32, d4);
        end
    endtask
`endif

    initial begin
        reset_i = 1; freeze_i = 0; v_i = 0; instret_i = 0; reason_i = '0;
        clear_i = 0; snapshot_i = 0; rd_v_i = 0; rd_addr_i = '0; rd_yumi_i = 0;
        model_reset();
        test_reset();
        test_basic_count();
        test_freeze_and_idle();
        test_saturation();
        test_clear_collision();
        test_read_timing();
        test_handshake();
        test_back_to_back();
`ifdef BP_PROFILER_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
